// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin share of the register-file write port between ALU and load unit,
// per-register pending-write scoreboard and decode stall. Optional commit-time forwarding under WB_BYPASS_EN.
module regfile_wb_scheduler #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned PCNT_W = 2
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          lsu_valid,
    input  logic [4:0]    lsu_rd,
    input  logic [DW-1:0] lsu_data,
    output logic          lsu_ready,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    output logic          stall,
    output logic [5:0]    A3,
    output logic [DW-1:0] WriteData,
    output logic          WE
`ifdef WB_BYPASS_EN
    ,
    output logic          byp1_valid,
    output logic [DW-1:0] byp1_data,
    output logic          byp2_valid,
    output logic [DW-1:0] byp2_data
`endif
);

    localparam logic [PCNT_W-1:0] CNT_MAX = '1;
    localparam logic [PCNT_W-1:0] CNT_ONE = PCNT_W'(1);

    logic              last_grant;   // 1: load unit was granted most recently
    logic              grant_alu;
    logic              grant_lsu;
    logic [4:0]        win_rd;
    logic [DW-1:0]     win_data;
    logic [PCNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;
    logic              hz1;
    logic              hz2;
    logic              full;
    logic              commit1;
    logic              commit2;

    // Round-robin arbitration; nothing is granted while in reset
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!Reset) begin
            if (alu_valid && (!lsu_valid || last_grant))
                grant_alu = 1'b1;
            else if (lsu_valid)
                grant_lsu = 1'b1;
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign win_rd    = grant_alu ? alu_rd   : lsu_rd;
    assign win_data  = grant_alu ? alu_data : lsu_data;

    always_ff @(posedge clock) begin
        if (Reset)
            last_grant <= 1'b1;
        else if (grant_alu)
            last_grant <= 1'b0;
        else if (grant_lsu)
            last_grant <= 1'b1;
    end

    // Write stage: one-cycle registered commit; rd==0 updates address/data but never writes
    always_ff @(posedge clock) begin
        if (Reset) begin
            WE        <= 1'b0;
            A3        <= '0;
            WriteData <= '0;
        end else if (grant_alu || grant_lsu) begin
            WE        <= (win_rd != 5'd0);
            A3        <= {1'b0, win_rd};
            WriteData <= win_data;
        end else begin
            WE        <= 1'b0;
        end
    end

    // Hazard detection from registered scoreboard and commit state
    always_comb begin
        commit1 = WE && (A3[4:0] == rs1) && (cnt[rs1] == CNT_ONE);
        commit2 = WE && (A3[4:0] == rs2) && (cnt[rs2] == CNT_ONE);
        hz1     = (rs1 != 5'd0) && (cnt[rs1] != '0);
        hz2     = (rs2 != 5'd0) && (cnt[rs2] != '0);
        full    = issue_valid && (cnt[issue_rd] == CNT_MAX);
`ifdef WB_BYPASS_EN
        stall   = (hz1 && !commit1) || (hz2 && !commit2) || full;
`else
        stall   = hz1 || hz2 || full;
`endif
    end

`ifdef WB_BYPASS_EN
    assign byp1_valid = (rs1 != 5'd0) && commit1;
    assign byp1_data  = WriteData;
    assign byp2_valid = (rs2 != 5'd0) && commit2;
    assign byp2_data  = WriteData;
`endif

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue_valid && !stall && (issue_rd == 5'(r));
            dec_vec[r] = WE && (A3[4:0] == 5'(r));
        end
    end

    // Pending-write counters; x0 never tracked, decrement saturates at zero
    always_ff @(posedge clock) begin
        cnt[0] <= '0;
        for (int r = 1; r < NREG; r++) begin
            if (Reset)
                cnt[r] <= '0;
            else if (inc_vec[r] && !dec_vec[r])
                cnt[r] <= cnt[r] + CNT_ONE;
            else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
                cnt[r] <= cnt[r] - CNT_ONE;
        end
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Write-back scheduler for the 32x32 register file.
- Shares the single write port (A3/WriteData/WE) between two producers: ALU result (port 0) and load unit (port 1). Arbitration is round-robin.
- Keeps a pending-write scoreboard per architectural register and drives the decode-stage stall signal.
- Sits between execute/memory stages and the register file write port.

Parameters:
- NREG, 32, number of architectural registers (x0..x31)
- DW, 32, data width
- PCNT_W, 2, width of per-register pending-write counter (max 2^PCNT_W-1 in flight)

Ports:
- clock  in  1  system clock, rising edge
- Reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU write-back request
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid  in  1  load write-back request
- lsu_rd  in  5  load destination register
- lsu_data  in  32  load data
- lsu_ready  out  1  load request accepted this cycle
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  5  destination of issued instruction
- rs1  in  5  decode source 1
- rs2  in  5  decode source 2
- stall  out  1  decode must hold (RAW hazard or counter full)
- A3  out  6  register file write address; bit 5 always 0
- WriteData  out  32  register file write data
- WE  out  1  register file write enable

Behaviour:
- Clock/reset: single clock `clock`. `Reset` is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - WE=0, A3=0, WriteData=0
  - all pending counters = 0
  - last_grant = 1, so ALU has priority on the first conflict
- Arbitration (combinational from inputs and last_grant):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - alu_ready/lsu_ready = grant. At most one is high per cycle. Neither is high during Reset.
  - last_grant updates only on an accepted request.
  - Requesters hold valid/rd/data until ready is seen.
- Write stage, one-cycle latency:
  - On accept in cycle N, cycle N+1 drives A3={1'b0,rd}, WriteData=data, WE=(rd!=0).
  - With no accept: WE=0; A3 and WriteData hold their previous values.
  - rd==0 requests are accepted but never write and never touch counters.
- Scoreboard, one counter cnt[r] per register r=1..31; cnt[0] is constant 0:
  - inc when issue_valid && issue_rd==r && r!=0 && !stall
  - dec when WE && A3[4:0]==r (registered commit)
  - inc and dec in the same cycle: cnt unchanged
  - dec when cnt==0: cnt stays 0 (protocol error, no wrap)
  - inc at max is impossible because stall blocks it
- stall (combinational from registered state):
  - high if (rs1!=0 && cnt[rs1]!=0), or (rs2!=0 && cnt[rs2]!=0), or (issue_valid && cnt[issue_rd]==max)
  - an issue while stall=1 is not counted
- Reset mid-operation:
  - the accepted request in flight is discarded (WE=0 next cycle)
  - counters clear and any request present that cycle gets no ready
- Write-after-write: multiple in-flight writes to the same rd are allowed up to the counter max. stall releases only when the count returns to 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - A source register with cnt==1 that is being committed this cycle (WE && A3[4:0]==rs) does not cause stall.
  - Adds outputs byp1_valid/byp1_data and byp2_valid/byp2_data. They are high and equal WriteData in that case, so decode can forward the committing value.
- Undefined:
  - No bypass ports.
  - stall follows the base rule exactly, giving one extra stall cycle on a commit-time hazard.

Test Plan:
- Reset held 2 cycles, then released with alu_valid=1 (rd=5, data=32'hDEADBEEF) in the same cycle Reset is high -> alu_ready=0 during Reset, WE=0. After release: ready, then WE=1, A3=6'd5, WriteData=32'hDEADBEEF one cycle later.
- alu_valid and lsu_valid both high for 4 cycles (rd 3/4) -> grants alternate ALU,LSU,ALU,LSU. WE pulses 4 consecutive cycles, A3=3,4,3,4.
- issue_valid rd=7, then rs1=7 for the following cycles -> stall=1 until the commit of rd=7 (WE, A3=7). stall=0 the cycle after the commit (base) or the commit cycle itself with byp1_valid=1 (WB_BYPASS_EN).
- Three issues to rd=9 with PCNT_W=2 and no commits -> cnt=3; a fourth issue_valid rd=9 gives stall=1 and cnt stays 3.
- lsu request with rd=0, data=32'h12345678 -> lsu_ready=1, WE=0 next cycle, all counters unchanged.
- Issue rd=10 in the same cycle as a commit of rd=10 with cnt=1 -> cnt stays 1 and stall on rs1=10 remains asserted.
